nano_boot_loader: RTL and testbench

Program loader and memory-port owner placed between the NanoCPU and its 256 x 16 program/data memory. After reset it holds the CPU in reset and accepts a byte stream over a valid/ready handshake. It assembles the bytes into 16-bit words and writes them into memory from address START_ADDR upward. When the load completes it releases the CPU and hands the memory port to it.

---
 rtl/nano_boot_loader.sv | 194 +++++++++++++++++++
 tb/tb_nano_boot_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nano_boot_loader.sv
// Boot loader that owns the NanoCPU memory port until a streamed program image is loaded.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (adds CSUM/ERR states).
module nano_boot_loader #(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [15:0]       cpu_dataW,
    input  logic              cpu_we,
    input  logic              cpu_ce,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_dataW,
    output logic              mem_we,
    output logic              mem_ce,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_RUN   = 3'd4,
        ST_CSUM  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_RUN   = 3'd4
    } state_t;
`endif

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);

    state_t            state_q;
    logic [8:0]        n_q;
    logic [8:0]        k_q;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_data_q;
    logic              mem_we_q;
    logic              mem_ce_q;
    logic              cpu_rst_q;
    logic              done_q;
    logic              run_s;
    logic              last_word_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
    logic              err_q;
`endif

    assign run_s       = (state_q == ST_RUN);
    assign last_word_s = ((k_q + 9'd1) == n_q);

`ifdef LOADER_CHECKSUM_EN
    assign rx_ready = (state_q == ST_COUNT) || (state_q == ST_HI) ||
                      (state_q == ST_LO)    || (state_q == ST_CSUM);
    assign err      = err_q;
`else
    assign rx_ready = (state_q == ST_COUNT) || (state_q == ST_HI) || (state_q == ST_LO);
    assign err      = 1'b0;
`endif

    // Once running, the CPU sees the memory port directly with no added latency.
    assign mem_address = run_s ? cpu_address : mem_addr_q;
    assign mem_dataW   = run_s ? cpu_dataW   : mem_data_q;
    assign mem_we      = run_s ? cpu_we      : mem_we_q;
    assign mem_ce      = run_s ? cpu_ce      : mem_ce_q;
    assign cpu_rst     = cpu_rst_q;
    assign done        = done_q;

    // Loader state machine with registered memory-port and status outputs.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q    <= ST_COUNT;
            n_q        <= 9'd0;
            k_q        <= 9'd0;
            hi_q       <= 8'd0;
            mem_addr_q <= '0;
            mem_data_q <= 16'd0;
            mem_we_q   <= 1'b0;
            mem_ce_q   <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (rx_valid) begin
                        // A count byte of zero encodes a full 256-word image.
                        n_q     <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        k_q     <= 9'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= 8'd0;
`endif
                        state_q <= ST_HI;
                    end else begin
                        state_q <= ST_COUNT;
                    end
                end
                ST_HI: begin
                    if (rx_valid) begin
                        hi_q    <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ rx_data;
`endif
                        state_q <= ST_LO;
                    end else begin
                        state_q <= ST_HI;
                    end
                end
                ST_LO: begin
                    if (rx_valid) begin
                        mem_addr_q <= START_A + k_q[ADDR_W-1:0];
                        mem_data_q <= {hi_q, rx_data};
                        mem_we_q   <= 1'b1;
                        mem_ce_q   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ rx_data;
`endif
                        state_q    <= ST_WRITE;
                    end else begin
                        state_q    <= ST_LO;
                    end
                end
                ST_WRITE: begin
                    mem_we_q <= 1'b0;
                    mem_ce_q <= 1'b0;
                    k_q      <= k_q + 9'd1;
                    if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q   <= ST_CSUM;
`else
                        state_q   <= ST_RUN;
                        cpu_rst_q <= 1'b0;
                        done_q    <= 1'b1;
`endif
                    end else begin
                        state_q <= ST_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == csum_q) begin
                            state_q   <= ST_RUN;
                            cpu_rst_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q   <= ST_ERR;
                            err_q     <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_CSUM;
                    end
                end
                ST_ERR: begin
                    state_q   <= ST_ERR;
                    mem_we_q  <= 1'b0;
                    mem_ce_q  <= 1'b0;
                    cpu_rst_q <= 1'b1;
                end
`endif
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    // Unreachable encodings fall back to a safe, CPU-held state.
                    state_q   <= ST_COUNT;
                    mem_we_q  <= 1'b0;
                    mem_ce_q  <= 1'b0;
                    cpu_rst_q <= 1'b1;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nano_boot_loader.sv
// Directed self-checking bench for nano_boot_loader with a behavioural 256 x 16 memory.
module tb_nano_boot_loader;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic [7:0]  cpu_address = 8'd0;
    logic [15:0] cpu_dataW = 16'd0;
    logic        cpu_we = 1'b0;
    logic        cpu_ce = 1'b0;
    logic [7:0]  mem_address;
    logic [15:0] mem_dataW;
    logic        mem_we;
    logic        mem_ce;
    logic        cpu_rst;
    logic        done;
    logic        err;

    logic [15:0] mem [256];
    logic        clr_mem = 1'b0;
    logic        prev_we = 1'b0;
    int          wr_cnt = 0;
    int          dbl_cnt = 0;
    int          stall_we = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 ck = ~ck;

    nano_boot_loader #(.ADDR_W(8), .START_ADDR(0)) dut (
        .ck(ck), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_address(cpu_address), .cpu_dataW(cpu_dataW), .cpu_we(cpu_we), .cpu_ce(cpu_ce),
        .mem_address(mem_address), .mem_dataW(mem_dataW), .mem_we(mem_we), .mem_ce(mem_ce),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    // Memory model, write counter and back-to-back loader write detector.
    always @(posedge ck) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hDEAD;
            wr_cnt  <= 0;
            dbl_cnt <= 0;
            prev_we <= 1'b0;
        end else begin
            prev_we <= mem_we;
            if (mem_we && mem_ce) begin
                mem[mem_address] <= mem_dataW;
                wr_cnt <= wr_cnt + 1;
            end
            if (mem_we && prev_we && !done) dbl_cnt <= dbl_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic do_reset(input logic clear);
        @(negedge ck);
        rst = 1'b1; clr_mem = clear; rx_valid = 1'b0;
        @(negedge ck);
        rst = 1'b0; clr_mem = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_valid = 1'b1; rx_data = b;
        while (!rx_ready && t < 20) begin
            @(negedge ck);
            t++;
        end
        check_eq("accept", rx_ready, 1'b1);
        @(posedge ck);
        @(negedge ck);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge ck);
            if (mem_we) stall_we++;
        end
    endtask

    logic [7:0]  stream1 [9] = '{8'h04, 8'h01, 8'hE0, 8'h01, 8'hF1, 8'h02, 8'h02, 8'h02, 8'h13};
    logic [15:0] words1  [4] = '{16'h01E0, 16'h01F1, 16'h0202, 16'h0213};

    initial begin
        int bad;
        int rdy_hi;
        logic [7:0] hb;
        logic [7:0] lb;

        // Reset state
        do_reset(1'b1);
        check_eq("rst_cpu_rst", cpu_rst, 1'b1);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_rx_ready", rx_ready, 1'b1);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_mem_ce", mem_ce, 1'b0);
        check_eq("rst_mem_addr", mem_address, 8'h00);
        check_eq("rst_mem_data", mem_dataW, 16'h0000);

        // Full-rate load; CPU port driven but must be ignored while loading
        cpu_we = 1'b1; cpu_ce = 1'b1; cpu_address = 8'h77; cpu_dataW = 16'hBEEF;
        for (int i = 0; i < 9; i++) send_byte(stream1[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`else
        check_eq("last_write_we", mem_we, 1'b1);
        check_eq("write_rx_ready", rx_ready, 1'b0);
        check_eq("pre_run_cpu_rst", cpu_rst, 1'b1);
        check_eq("pre_run_done", done, 1'b0);
        @(negedge ck);
`endif
        check_eq("run_done", done, 1'b1);
        check_eq("run_cpu_rst", cpu_rst, 1'b0);
        check_eq("cpu_ignored", mem[8'h77], 16'hDEAD);
        check_eq("fast_wr_cnt", wr_cnt, 4);
        check_eq("single_pulse", dbl_cnt, 0);
        cpu_we = 1'b0; cpu_ce = 1'b0;
        for (int i = 0; i < 4; i++) check_eq("fast_mem", mem[i], words1[i]);

        // RUN: CPU owns memory, loader refuses bytes
        rx_valid = 1'b1; rx_data = 8'hAA;
        cpu_address = 8'h0F; cpu_dataW = 16'h5555; cpu_we = 1'b1; cpu_ce = 1'b1;
        #1;
        check_eq("run_mem_addr", mem_address, 8'h0F);
        check_eq("run_mem_data", mem_dataW, 16'h5555);
        check_eq("run_mem_we", mem_we, 1'b1);
        check_eq("run_mem_ce", mem_ce, 1'b1);
        @(negedge ck);
        cpu_we = 1'b0; cpu_ce = 1'b0;
        check_eq("run_cpu_write", mem[8'h0F], 16'h5555);
        rdy_hi = 0;
        repeat (4) begin
            @(negedge ck);
            if (rx_ready) rdy_hi++;
        end
        check_eq("run_rx_ready", rdy_hi, 0);
        check_eq("run_done_hold", done, 1'b1);
        rx_valid = 1'b0;

        // Reset from RUN re-holds the CPU
        do_reset(1'b1);
        check_eq("runrst_cpu_rst", cpu_rst, 1'b1);
        check_eq("runrst_done", done, 1'b0);
        check_eq("runrst_rx_ready", rx_ready, 1'b1);

        // Same stream with 5-cycle stalls between bytes
        stall_we = 0;
        for (int i = 0; i < 9; i++) begin
            send_byte(stream1[i]);
            idle(5);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
        idle(2);
`endif
        check_eq("stall_no_we", stall_we, 0);
        check_eq("stall_wr_cnt", wr_cnt, 4);
        check_eq("stall_done", done, 1'b1);
        for (int i = 0; i < 4; i++) check_eq("stall_mem", mem[i], words1[i]);

        // Reset mid-word: partial second word discarded
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) send_byte(stream1[i]);
        do_reset(1'b0);
        check_eq("midrst_cpu_rst", cpu_rst, 1'b1);
        check_eq("midrst_rx_ready", rx_ready, 1'b1);
        check_eq("midrst_mem_we", mem_we, 1'b0);
        check_eq("midrst_wr_cnt", wr_cnt, 1);
        check_eq("midrst_mem0", mem[0], 16'h01E0);
        check_eq("midrst_mem1", mem[1], 16'hDEAD);
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h11);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        idle(2);
        check_eq("reload_mem0", mem[0], 16'h1111);
        check_eq("reload_wr_cnt", wr_cnt, 2);
        check_eq("reload_done", done, 1'b1);

        // C=0: 256 words of counting pattern
        do_reset(1'b1);
        send_byte(8'h00);
        for (int i = 0; i < 512; i++) send_byte(i[7:0]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        idle(2);
        bad = 0;
        for (int j = 0; j < 256; j++) begin
            hb = 8'(2 * j);
            lb = 8'(2 * j + 1);
            if (mem[j] !== {hb, lb}) bad++;
        end
        check_eq("full_bad_words", bad, 0);
        check_eq("full_wr_cnt", wr_cnt, 256);
        check_eq("full_done", done, 1'b1);
        check_eq("full_err", err, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum releases the CPU
        do_reset(1'b1);
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
        check_eq("csum_ok_done", done, 1'b1);
        check_eq("csum_ok_err", err, 1'b0);
        check_eq("csum_ok_cpu_rst", cpu_rst, 1'b0);
        check_eq("csum_ok_mem", mem[0], 16'h1234);

        // Bad checksum aborts and keeps the CPU held
        do_reset(1'b1);
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
        rx_valid = 1'b1; rx_data = 8'h55;
        idle(3);
        rx_valid = 1'b0;
        check_eq("csum_bad_err", err, 1'b1);
        check_eq("csum_bad_cpu_rst", cpu_rst, 1'b1);
        check_eq("csum_bad_done", done, 1'b0);
        check_eq("csum_bad_rx_ready", rx_ready, 1'b0);
        check_eq("csum_bad_mem_we", mem_we, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
